// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor with a start/busy/done handshake.
// Processes DIGIT bits per cycle. The result, carry-out and signed overflow
// registers update only on the completion edge.
module add_sub_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_s,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DigW = DIGIT + 1;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DigW-1:0]  dig;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             msb_cin;
  logic [WIDTH-1:0] part_shift;
  logic             last;

  // Digit adder over the low DIGIT bits of A and B' plus the running carry
  always_comb begin
    dig      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DigW'(carry_q);
    dig_sum  = dig[DIGIT-1:0];
    dig_cout = dig[DIGIT];
    // Sum bit is a ^ b ^ cin, so the carry into the digit MSB is recoverable
    msb_cin    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_sum[DIGIT-1];
    // New digit enters from the MSB side; after N digits the word is aligned
    part_shift = (part_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
    last       = (cnt_q == CntW'(N - 1));
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b ^ {WIDTH{i_s}};
          carry_d = i_s;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        part_d  = part_shift;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          sum_d   = part_shift;
          cout_d  = dig_cout;
          ovf_d   = msb_cin ^ dig_cout;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; asynchronous reset aborts any operation in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // All outputs come straight from flops
  always_comb begin
    o_busy = (state_q == StBusy);
    o_done = done_q;
    o_sum  = sum_q;
    o_cout = cout_q;
    o_ovf  = ovf_q;
  end

endmodule

// File: tb/tb_add_sub_serial.sv
// Directed and swept checks for add_sub_serial at DIGIT = 4, 16 and 1.
module tb_add_sub_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ia = '0;
  logic [15:0] ib = '0;
  logic        is = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  // Sweep instances: index 0 is DIGIT=16 (N=1), index 1 is DIGIT=1 (N=16)
  logic        sw_start [2];
  logic [15:0] sw_a     [2];
  logic [15:0] sw_b     [2];
  logic        sw_s     [2];
  logic        sw_busy  [2];
  logic        sw_done  [2];
  logic [15:0] sw_sum   [2];
  logic        sw_cout  [2];
  logic        sw_ovf   [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  add_sub_serial #(.WIDTH(16), .DIGIT(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(ia), .i_b(ib), .i_s(is),
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout), .o_ovf(ovf)
  );

  add_sub_serial #(.WIDTH(16), .DIGIT(16)) u_dut_n1 (
    .i_clk(clk), .i_rst(rst), .i_start(sw_start[0]), .i_a(sw_a[0]), .i_b(sw_b[0]),
    .i_s(sw_s[0]), .o_busy(sw_busy[0]), .o_done(sw_done[0]), .o_sum(sw_sum[0]),
    .o_cout(sw_cout[0]), .o_ovf(sw_ovf[0])
  );

  add_sub_serial #(.WIDTH(16), .DIGIT(1)) u_dut_n16 (
    .i_clk(clk), .i_rst(rst), .i_start(sw_start[1]), .i_a(sw_a[1]), .i_b(sw_b[1]),
    .i_s(sw_s[1]), .o_busy(sw_busy[1]), .o_done(sw_done[1]), .o_sum(sw_sum[1]),
    .o_cout(sw_cout[1]), .o_ovf(sw_ovf[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {ovf, cout, sum}
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
    logic [15:0] bb;
    logic [16:0] r;
    logic        v;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, s};
    v  = (a[15] == bb[15]) && (r[15] != a[15]);
    return {v, r};
  endfunction

  // Waits from just after the accept edge until done; returns edges waited
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (done !== 1'b1) check("busy_during_op", busy, 1);
    end
    check("busy_low_at_done", busy, 0);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] e_sum, input logic e_cout,
                       input logic e_ovf);
    int cycles;
    @(negedge clk);
    start = 1'b1; ia = a; ib = b; is = s;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cycles);
    check({tag, "_latency"}, cycles, 4);
    check({tag, "_sum"}, sum, e_sum);
    check({tag, "_cout"}, cout, e_cout);
    check({tag, "_ovf"}, ovf, e_ovf);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic sweep(input int k, input int n);
    logic [15:0] a, b;
    logic        s;
    logic [17:0] r;
    int          cycles;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      r = ref_op(a, b, s);
      @(negedge clk);
      sw_start[k] = 1'b1; sw_a[k] = a; sw_b[k] = b; sw_s[k] = s;
      @(posedge clk); #1;
      sw_start[k] = 1'b0;
      sw_a[k] = ~a; sw_b[k] = ~b; sw_s[k] = ~s;
      cycles = 0;
      while (sw_done[k] !== 1'b1 && cycles < 40) begin
        @(posedge clk); #1;
        cycles++;
      end
      check($sformatf("sweep_n%0d_latency", n), cycles, n);
      check($sformatf("sweep_n%0d_sum", n), sw_sum[k], r[15:0]);
      check($sformatf("sweep_n%0d_cout", n), sw_cout[k], r[16]);
      check($sformatf("sweep_n%0d_ovf", n), sw_ovf[k], r[17]);
    end
  endtask

  initial begin
    int cycles;
    for (int k = 0; k < 2; k++) begin
      sw_start[k] = 1'b0; sw_a[k] = '0; sw_b[k] = '0; sw_s[k] = 1'b0;
    end

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;

    do_op("add", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("add_carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Start pulse while busy, with new operands, is ignored
    @(negedge clk);
    start = 1'b1; ia = 16'h1111; ib = 16'h2222; is = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; ia = 16'hF000; ib = 16'h0F00; is = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 2;
    while (done !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("ignore_latency", cycles, 4);
    check("ignore_sum", sum, 16'h3333);
    @(posedge clk); #1;
    check("ignore_no_second_op", busy, 0);

    // Start held through done; operands changed mid-op
    @(negedge clk);
    start = 1'b1; ia = 16'h0100; ib = 16'h0001; is = 1'b1;
    @(posedge clk); #1;
    ia = 16'hABCD; ib = 16'h1111; is = 1'b0;
    wait_done(cycles);
    check("held_first_latency", cycles, 4);
    check("held_first_sum", sum, 16'h00FF);
    check("held_first_cout", cout, 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("held_accept_busy", busy, 1);
    check("held_accept_done", done, 0);
    cycles = 1;
    while (done !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("held_done_spacing", cycles, 5);
    check("held_second_sum", sum, 16'hBCDE);
    check("held_second_cout", cout, 0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; ia = 16'h4444; ib = 16'h1111; is = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum, 0);
    check("midrst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", done, 0);
    end
    do_op("post_rst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);

    sweep(0, 1);
    sweep(1, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised digit-serial adder/subtractor with a start/busy/done handshake. It is the multi-cycle successor of the 4-bit combinational add/sub. Each cycle it processes `DIGIT` bits of a `WIDTH`-bit operation and reports the sum, carry-out and signed overflow. It serves datapaths that trade latency for adder area, and controllers that need a registered, handshaked arithmetic unit.

## Interface
- `WIDTH`, 16, operand/result width in bits; must be ≥ 1.
- `DIGIT`, 4, bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`, `WIDTH % DIGIT == 0`; `N = WIDTH/DIGIT`.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  request; sampled only while idle.
- `i_a`  in  `WIDTH`  operand A, captured on accepted start.
- `i_b`  in  `WIDTH`  operand B, captured on accepted start.
- `i_s`  in  1  mode, captured on accepted start: 0 = A+B, 1 = A−B.
- `o_busy`  out  1  high while an operation is in progress.
- `o_done`  out  1  one-cycle pulse when the result registers update.
- `o_sum`  out  `WIDTH`  result, held until the next completion.
- `o_cout`  out  1  carry out of the MSB. For subtract, 1 = no borrow (A ≥ B unsigned).
- `o_ovf`  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, BUSY.
- **IDLE + `i_start`=1 (accept):**
  - capture A;
  - capture B XOR {`WIDTH`{`i_s`}};
  - carry ← `i_s`;
  - digit counter ← 0;
  - go to BUSY.
- **IDLE + `i_start`=0:** no change.
- **BUSY, each cycle:**
  - add the low `DIGIT` bits of A, B' and carry;
  - shift the `DIGIT` result bits into the partial-sum register from the MSB side;
  - shift A and B' right by `DIGIT`;
  - update carry with the digit carry-out;
  - increment the counter.
- **BUSY, counter == N−1 (last digit):**
  - load `o_sum` with the full assembled result;
  - `o_cout` ← digit carry-out;
  - `o_ovf` ← carry into bit `WIDTH`−1 XOR carry out of bit `WIDTH`−1 (both come from the last digit);
  - assert `o_done`;
  - go to IDLE.
- `i_start` while BUSY is ignored. `i_a`, `i_b` and `i_s` changing after acceptance have no effect.
- Arithmetic is modulo 2^`WIDTH`. No saturation.
- `o_sum`, `o_cout` and `o_ovf` change only on a completion edge. Partial results are never visible.
- **`DIGIT` == `WIDTH` (N=1):** a single BUSY cycle; behaviour is otherwise identical.
- **Reset (async, any time, including mid-operation):**
  - state → IDLE; counter, carry and internal registers → 0;
  - `o_busy`=0, `o_done`=0, `o_sum`=0, `o_cout`=0, `o_ovf`=0;
  - an aborted operation never produces `o_done`.
- **Reset release:** the first edge with `i_rst`=0 may accept a start.

## Timing
- Edge 0: start sampled high in IDLE.
- Edges 1..N: process digits 0..N−1.
- `o_busy`=1 in the N cycles after edge 0. It falls on edge N.
- `o_done`=1 for exactly the one cycle after edge N. The new `o_sum`/`o_cout`/`o_ovf` are valid in that same cycle.
- Latency is N cycles from accepted start to `o_done`.
- The state is IDLE during the `o_done` cycle, so a start held high there is accepted at edge N+1.
- Maximum throughput is one operation per N+1 cycles.
- `o_busy` and `o_done` are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Unless noted, `WIDTH`=16, `DIGIT`=4 (N=4).
- **Basic add:** `i_a`=0x1234, `i_b`=0x4321, `i_s`=0, one-cycle start → `o_busy` high 4 cycles, then `o_done` pulse. `o_sum`=0x5555, `o_cout`=0, `o_ovf`=0.
- **Subtract with borrow:** 0x0005 − 0x0007 → `o_sum`=0xFFFE, `o_cout`=0, `o_ovf`=0. Then 0x0007 − 0x0005 → 0x0002, `o_cout`=1, `o_ovf`=0.
- **Overflow/carry corners:**
  - 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1;
  - 0xFFFF+0x0001 → 0x0000, cout=1, ovf=0;
  - 0x8000−0x0001 → 0x7FFF, cout=1, ovf=1.
- **Handshake:**
  - a start pulse while busy with new operands → ignored; the result matches the first operands;
  - start held high through `o_done` → second op accepted the next edge, second `o_done` exactly 5 cycles after the first;
  - operands changed mid-op → no effect on the result.
- **Reset mid-operation:** assert `i_rst` asynchronously 2 cycles after start → outputs immediately 0, no `o_done`. After release, 0x00FF+0x0F01 → 0x1000, cout=0, ovf=0 after 4 cycles.
- **Parameter sweep:** `DIGIT`=16 (N=1) and `DIGIT`=1 (N=16), 1000 random operands/modes each → `o_sum`/`o_cout`/`o_ovf` match the reference model, and `o_done` arrives exactly N cycles after each accepted start.
